// File: rtl/cv32e40x_obi_req_bridge.sv
// OBI request bridge downstream of the instruction-side MPU.
// Optional stray-response filtering: define CV32E40X_OBI_RESP_CHECK_EN.
module cv32e40x_obi_req_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trans_valid_i,
  output logic        trans_ready_o,
  input  logic [31:0] trans_addr_i,
  input  logic [2:0]  trans_prot_i,
  input  logic [1:0]  trans_memtype_i,
  input  logic        trans_dbg_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        resp_unexp_o,
  output logic [2:0]  outstanding_cnt_o,
  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic [2:0]  obi_prot_o,
  output logic [1:0]  obi_memtype_o,
  output logic        obi_dbg_o,
  input  logic        obi_rvalid_i,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_err_i
);

  typedef enum logic {
    TRANSPARENT,
    REGISTERED
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [31:0] addr_q;
  logic [2:0]  prot_q;
  logic [1:0]  memtype_q;
  logic        dbg_q;
  logic        full;
  logic        req;
  logic        ready;
  logic        capture;
  logic        grant;
  logic        stray;
  logic        rsp_acc;

  assign full = (cnt_q == 3'(MAX_OUTSTANDING));

  // rst_n gates req so a held request drops the instant reset asserts
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    ready   = 1'b0;
    capture = 1'b0;
    unique case (1'b1)
      (state_q == TRANSPARENT): begin
        req   = trans_valid_i && !full && rst_n;
        ready = !full;
        if (req && !obi_gnt_i) begin
          capture = 1'b1;
          state_d = REGISTERED;
        end
      end
      (state_q == REGISTERED): begin
        req = rst_n;
        if (obi_gnt_i) begin
          state_d = TRANSPARENT;
        end
      end
      default: ;
    endcase
  end

  assign obi_req_o     = req;
  assign trans_ready_o = ready;

  assign obi_addr_o    = (state_q == REGISTERED) ? addr_q    : trans_addr_i;
  assign obi_prot_o    = (state_q == REGISTERED) ? prot_q    : trans_prot_i;
  assign obi_memtype_o = (state_q == REGISTERED) ? memtype_q : trans_memtype_i;
  assign obi_dbg_o     = (state_q == REGISTERED) ? dbg_q     : trans_dbg_i;

  assign grant   = req && obi_gnt_i;
  assign stray   = obi_rvalid_i && (cnt_q == 3'd0) && !grant;
  assign rsp_acc = obi_rvalid_i && !stray;

  always_comb begin
    cnt_d = cnt_q;
    if (grant && !rsp_acc) begin
      cnt_d = cnt_q + 3'd1;
    end else if (rsp_acc && !grant) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  assign outstanding_cnt_o = cnt_q;
  assign resp_rdata_o      = obi_rdata_i;
  assign resp_err_o        = obi_err_i;

`ifdef CV32E40X_OBI_RESP_CHECK_EN
  assign resp_valid_o = rsp_acc;
  assign resp_unexp_o = stray;
`else
  assign resp_valid_o = obi_rvalid_i;
  assign resp_unexp_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRANSPARENT;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= 32'd0;
      prot_q    <= 3'd0;
      memtype_q <= 2'd0;
      dbg_q     <= 1'b0;
    end else if (capture) begin
      addr_q    <= trans_addr_i;
      prot_q    <= trans_prot_i;
      memtype_q <= trans_memtype_i;
      dbg_q     <= trans_dbg_i;
    end
  end

endmodule

// File: tb/tb_cv32e40x_obi_req_bridge.sv
// Bench for cv32e40x_obi_req_bridge: directed scenarios plus
// randomized traffic against a transaction-level model.
module tb_cv32e40x_obi_req_bridge;

  localparam int MAXO = 2;

  logic        clk;
  logic        rst_n;
  logic        trans_valid;
  logic        trans_ready;
  logic [31:0] trans_addr;
  logic [2:0]  trans_prot;
  logic [1:0]  trans_memtype;
  logic        trans_dbg;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_unexp;
  logic [2:0]  cnt;
  logic        obi_req;
  logic        obi_gnt;
  logic [31:0] obi_addr;
  logic [2:0]  obi_prot;
  logic [1:0]  obi_memtype;
  logic        obi_dbg;
  logic        obi_rvalid;
  logic [31:0] obi_rdata;
  logic        obi_err;

  int total;
  int bad;

  // model: count of outstanding beats and an optional stalled request
  int          m_cnt;
  bit          m_pend;
  logic [31:0] m_addr;
  logic [2:0]  m_prot;
  logic [1:0]  m_mem;
  logic        m_dbg;

  logic        e_req;
  logic        e_ready;
  logic [31:0] e_addr;
  logic [2:0]  e_prot;
  logic [1:0]  e_mem;
  logic        e_dbg;
  logic        e_rv;
  logic        e_unexp;
  logic [2:0]  e_cnt;
  bit          e_stray;
  bit          e_grant;

  cv32e40x_obi_req_bridge #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .trans_valid_i     (trans_valid),
    .trans_ready_o     (trans_ready),
    .trans_addr_i      (trans_addr),
    .trans_prot_i      (trans_prot),
    .trans_memtype_i   (trans_memtype),
    .trans_dbg_i       (trans_dbg),
    .resp_valid_o      (resp_valid),
    .resp_rdata_o      (resp_rdata),
    .resp_err_o        (resp_err),
    .resp_unexp_o      (resp_unexp),
    .outstanding_cnt_o (cnt),
    .obi_req_o         (obi_req),
    .obi_gnt_i         (obi_gnt),
    .obi_addr_o        (obi_addr),
    .obi_prot_o        (obi_prot),
    .obi_memtype_o     (obi_memtype),
    .obi_dbg_o         (obi_dbg),
    .obi_rvalid_i      (obi_rvalid),
    .obi_rdata_i       (obi_rdata),
    .obi_err_i         (obi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic calc();
    e_req   = m_pend || (trans_valid && m_cnt < MAXO);
    e_ready = !m_pend && (m_cnt < MAXO);
    e_addr  = m_pend ? m_addr : trans_addr;
    e_prot  = m_pend ? m_prot : trans_prot;
    e_mem   = m_pend ? m_mem  : trans_memtype;
    e_dbg   = m_pend ? m_dbg  : trans_dbg;
    e_grant = e_req && obi_gnt;
    e_stray = obi_rvalid && (m_cnt == 0) && !e_grant;
`ifdef CV32E40X_OBI_RESP_CHECK_EN
    e_rv    = obi_rvalid && !e_stray;
    e_unexp = e_stray;
`else
    e_rv    = obi_rvalid;
    e_unexp = 1'b0;
`endif
    e_cnt   = 3'(m_cnt);
  endtask

  task automatic drive(input bit v, input logic [31:0] a,
                       input bit g, input bit rv,
                       input logic [31:0] rd, input bit er);
    @(negedge clk);
    trans_valid   = v;
    trans_addr    = a;
    trans_prot    = a[2:0];
    trans_memtype = a[5:4];
    trans_dbg     = a[8];
    obi_gnt       = g;
    obi_rvalid    = rv;
    obi_rdata     = rd;
    obi_err       = er;
    #1;
    calc();
  endtask

  // model advance at the coming rising edge
  task automatic adv();
    if (m_pend) begin
      if (obi_gnt) m_pend = 0;
    end else if (e_req && !obi_gnt) begin
      m_pend = 1;
      m_addr = trans_addr;
      m_prot = trans_prot;
      m_mem  = trans_memtype;
      m_dbg  = trans_dbg;
    end
    if (e_grant) m_cnt = m_cnt + 1;
    if (obi_rvalid && !e_stray) m_cnt = m_cnt - 1;
  endtask

  task automatic idle();
    drive(0, 32'h0, 0, 0, 32'h0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) begin
      if (m_cnt == 0 && !m_pend) break;
      drive(0, 32'h0, 1, m_cnt > 0, 32'h5a5a_0000, 0);
      adv();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trans_valid = 0; trans_addr = 0; trans_prot = 0;
    trans_memtype = 0; trans_dbg = 0; obi_gnt = 0;
    obi_rvalid = 0; obi_rdata = 0; obi_err = 0;
    m_cnt = 0; m_pend = 0;
    m_addr = 0; m_prot = 0; m_mem = 0; m_dbg = 0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (obi_req !== 1'b0) begin
      bad++; $display("FAIL reset_req got=%b exp=0", obi_req);
    end
    total++;
    if (trans_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", trans_ready);
    end
    total++;
    if (resp_valid !== 1'b0) begin
      bad++; $display("FAIL reset_rvalid got=%b exp=0", resp_valid);
    end
    total++;
    if (resp_unexp !== 1'b0) begin
      bad++; $display("FAIL reset_unexp got=%b exp=0", resp_unexp);
    end
    total++;
    if (cnt !== 3'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_immediate_grant();
    drive(1, 32'h0000_1000, 1, 0, 32'h0, 0);
    total++;
    if (obi_req !== 1'b1 || obi_addr !== 32'h1000 || trans_ready !== 1'b1) begin
      bad++;
      $display("FAIL imm_req req=%b addr=%h rdy=%b exp 1/1000/1",
               obi_req, obi_addr, trans_ready);
    end
    adv();
    drive(0, 32'h0, 0, 1, 32'hDEAD_BEEF, 0);
    total++;
    if (cnt !== 3'd1) begin
      bad++; $display("FAIL imm_cnt1 got=%0d exp=1", cnt);
    end
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL imm_resp v=%b d=%h exp 1/deadbeef", resp_valid, resp_rdata);
    end
    adv();
    idle();
    total++;
    if (cnt !== 3'd0 || trans_ready !== 1'b1) begin
      bad++; $display("FAIL imm_cnt0 cnt=%0d rdy=%b exp 0/1", cnt, trans_ready);
    end
  endtask

  task automatic test_stall();
    drive(1, 32'h0000_2000, 0, 0, 32'h0, 0);
    adv();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h0000_3000, 0, 0, 32'h0, 0);
      total++;
      if (obi_req !== 1'b1 || obi_addr !== 32'h2000 || trans_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold req=%b addr=%h rdy=%b exp 1/2000/0",
                 obi_req, obi_addr, trans_ready);
      end
      total++;
      if (obi_prot !== 3'd0 || obi_memtype !== 2'd0 || obi_dbg !== 1'b0) begin
        bad++;
        $display("FAIL stall_attr p=%0d m=%0d d=%b exp 0/0/0",
                 obi_prot, obi_memtype, obi_dbg);
      end
      adv();
    end
    drive(1, 32'h0000_3000, 1, 0, 32'h0, 0);
    total++;
    if (obi_addr !== 32'h2000) begin
      bad++; $display("FAIL stall_gnt_addr got=%h exp=2000", obi_addr);
    end
    adv();
    idle();
    total++;
    if (cnt !== 3'd1 || trans_ready !== 1'b1 || obi_req !== 1'b0) begin
      bad++;
      $display("FAIL stall_after cnt=%0d rdy=%b req=%b exp 1/1/0",
               cnt, trans_ready, obi_req);
    end
    drain();
  endtask

  task automatic test_full();
    drive(1, 32'h0000_4000, 1, 0, 32'h0, 0);
    adv();
    drive(1, 32'h0000_4004, 1, 0, 32'h0, 0);
    adv();
    drive(1, 32'h0000_4008, 1, 0, 32'h0, 0);
    total++;
    if (cnt !== 3'd2 || obi_req !== 1'b0 || trans_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_block cnt=%0d req=%b rdy=%b exp 2/0/0",
               cnt, obi_req, trans_ready);
    end
    adv();
    drive(1, 32'h0000_4008, 0, 1, 32'h1111_2222, 0);
    total++;
    if (trans_ready !== 1'b0 || obi_req !== 1'b0) begin
      bad++;
      $display("FAIL full_same_cycle rdy=%b req=%b exp 0/0", trans_ready, obi_req);
    end
    adv();
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    total++;
    if (trans_ready !== 1'b1 || cnt !== 3'd1) begin
      bad++; $display("FAIL full_freed rdy=%b cnt=%0d exp 1/1", trans_ready, cnt);
    end
    adv();
    drain();
  endtask

  task automatic test_grant_rvalid();
    drive(1, 32'h0000_5000, 1, 0, 32'h0, 0);
    adv();
    drive(1, 32'h0000_5004, 1, 1, 32'hCAFE_0001, 1);
    total++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin
      bad++; $display("FAIL gr_err v=%b err=%b exp 1/1", resp_valid, resp_err);
    end
    adv();
    idle();
    total++;
    if (cnt !== 3'd1) begin
      bad++; $display("FAIL gr_cnt got=%0d exp=1", cnt);
    end
    drain();
  endtask

  task automatic test_stray();
    drive(0, 32'h0, 0, 1, 32'h7777_7777, 0);
    total++;
`ifdef CV32E40X_OBI_RESP_CHECK_EN
    if (resp_valid !== 1'b0 || resp_unexp !== 1'b1) begin
      bad++; $display("FAIL stray v=%b u=%b exp 0/1", resp_valid, resp_unexp);
    end
`else
    if (resp_valid !== 1'b1 || resp_unexp !== 1'b0) begin
      bad++; $display("FAIL stray v=%b u=%b exp 1/0", resp_valid, resp_unexp);
    end
`endif
    adv();
    idle();
    total++;
    if (cnt !== 3'd0) begin
      bad++; $display("FAIL stray_cnt got=%0d exp=0", cnt);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h0000_6000, 1, 0, 32'h0, 0);
    adv();
    drive(1, 32'h0000_6004, 0, 0, 32'h0, 0);
    adv();
    drive(1, 32'h0000_6008, 0, 0, 32'h0, 0);
    total++;
    if (obi_req !== 1'b1 || cnt !== 3'd1) begin
      bad++; $display("FAIL rmid_pre req=%b cnt=%0d exp 1/1", obi_req, cnt);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (obi_req !== 1'b0 || cnt !== 3'd0) begin
      bad++; $display("FAIL rmid_drop req=%b cnt=%0d exp 0/0", obi_req, cnt);
    end
    trans_valid = 0;
    obi_gnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    m_pend = 0;
    idle();
    total++;
    if (trans_ready !== 1'b1 || obi_req !== 1'b0) begin
      bad++; $display("FAIL rmid_after rdy=%b req=%b exp 1/0", trans_ready, obi_req);
    end
    adv();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom(),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom(), $urandom_range(0, 1) == 1);
      total++;
      if (obi_req !== e_req || trans_ready !== e_ready || cnt !== e_cnt) begin
        bad++;
        $display("FAIL rnd_ctl i=%0d req=%b/%b rdy=%b/%b cnt=%0d/%0d",
                 i, obi_req, e_req, trans_ready, e_ready, cnt, e_cnt);
      end
      total++;
      if (obi_addr !== e_addr || obi_prot !== e_prot ||
          obi_memtype !== e_mem || obi_dbg !== e_dbg) begin
        bad++;
        $display("FAIL rnd_fields i=%0d addr=%h/%h prot=%0d/%0d",
                 i, obi_addr, e_addr, obi_prot, e_prot);
      end
      total++;
      if (resp_valid !== e_rv || resp_unexp !== e_unexp ||
          resp_rdata !== obi_rdata || resp_err !== obi_err) begin
        bad++;
        $display("FAIL rnd_resp i=%0d v=%b/%b u=%b/%b",
                 i, resp_valid, e_rv, resp_unexp, e_unexp);
      end
      adv();
    end
    drain();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_immediate_grant();
    test_stall();
    test_full();
    test_grant_rvalid();
    test_stray();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40x_obi_req_bridge.md
Name: cv32e40x_obi_req_bridge

Overview:
- Bus-side stage directly downstream of the instruction-side MPU.
- Takes the MPU's forwarded transaction (valid/ready handshake, may drop or change attributes at any time while unaccepted) and drives the OBI request channel.
- Enforces OBI stability: address and attributes held unchanged from req high until gnt.
- Tracks outstanding transactions, limits them to a maximum, and forwards OBI responses back towards the MPU.

Parameters:
- MAX_OUTSTANDING, 2, maximum number of granted-but-unresponded OBI transactions; legal range 1..7.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- trans_valid_i  input  1  transaction request from MPU
- trans_ready_o  output  1  transaction accepted by bridge
- trans_addr_i  input  32  request address
- trans_prot_i  input  3  protection attributes
- trans_memtype_i  input  2  memtype: [0] bufferable, [1] cacheable
- trans_dbg_i  input  1  debug-mode access
- resp_valid_o  output  1  response valid towards MPU
- resp_rdata_o  output  32  response data
- resp_err_o  output  1  bus error on response
- resp_unexp_o  output  1  response received with zero outstanding (see Optional Feature)
- outstanding_cnt_o  output  3  current outstanding count
- obi_req_o  output  1  OBI req
- obi_gnt_i  input  1  OBI gnt
- obi_addr_o  output  32  OBI addr
- obi_prot_o  output  3  OBI prot
- obi_memtype_o  output  2  OBI memtype
- obi_dbg_o  output  1  OBI dbg
- obi_rvalid_i  input  1  OBI rvalid
- obi_rdata_i  input  32  OBI rdata
- obi_err_i  input  1  OBI err

Behaviour:
- Reset state:
  - state = TRANSPARENT; cnt = 0; held registers = 0.
  - obi_req_o = 0 (valid low), trans_ready_o = 1.
  - resp_valid_o = 0, resp_unexp_o = 0, outstanding_cnt_o = 0.
- Define full = (cnt == MAX_OUTSTANDING).
- TRANSPARENT state:
  - obi_req_o = trans_valid_i && !full.
  - OBI addr/prot/memtype/dbg driven combinationally from trans_* inputs.
  - trans_ready_o = !full; a transaction is accepted on trans_valid_i && trans_ready_o, granted or not.
  - If obi_req_o && !obi_gnt_i: capture addr/prot/memtype/dbg into held registers, go to REGISTERED.
  - If obi_req_o && obi_gnt_i: zero-latency pass-through, stay in TRANSPARENT.
- REGISTERED state:
  - obi_req_o = 1; OBI fields driven from held registers, stable regardless of trans_* changes.
  - trans_ready_o = 0.
  - On obi_gnt_i: return to TRANSPARENT next cycle. No back-to-back issue from REGISTERED in the grant cycle.
- Counter cnt (3 bits, exported as outstanding_cnt_o):
  - +1 on obi_req_o && obi_gnt_i.
  - -1 on an accepted rvalid (see Optional Feature).
  - Grant and rvalid in the same cycle: unchanged.
  - Never underflows below 0; cannot exceed MAX_OUTSTANDING, since accept requires !full and at most one request is ungranted.
- Response path is combinational, zero latency:
  - resp_valid_o = obi_rvalid_i (subject to feature).
  - resp_rdata_o = obi_rdata_i; resp_err_o = obi_err_i.
  - Responses return in order; no response-side backpressure (the MPU is always ready).
- Boundary cases:
  - Full in TRANSPARENT: obi_req_o = 0 and trans_ready_o = 0 until an rvalid frees a slot; readiness is restored in the same cycle rvalid arrives only via the registered cnt, i.e. the next cycle.
  - Reset asserted mid-REGISTERED: request dropped immediately (obi_req_o = 0 asynchronously); cnt cleared.

Optional Feature:
- Macro: CV32E40X_OBI_RESP_CHECK_EN.
- Defined:
  - obi_rvalid_i while cnt == 0 (and no grant in the same cycle) is dropped: resp_valid_o = 0.
  - resp_unexp_o = 1 for that cycle (combinational, one pulse per stray beat); cnt stays 0.
- Not defined:
  - Every rvalid is forwarded; cnt saturates at 0.
  - resp_unexp_o tied to 0.

Test Plan:
- Immediate grant: valid=1, addr=0x0000_1000, gnt=1 in the same cycle -> obi_req_o=1, obi_addr_o=0x1000, trans_ready_o=1, state stays TRANSPARENT, cnt 0->1; rvalid with rdata=0xDEAD_BEEF next cycle -> resp_valid_o=1, rdata forwarded, cnt=0.
- Stall stability: addr=0x2000 with gnt=0 for 3 cycles while trans_addr_i changes to 0x3000 -> obi_addr_o stays 0x2000, trans_ready_o=0 in REGISTERED; gnt on cycle 4 -> cnt=1, TRANSPARENT.
- Full limit (MAX_OUTSTANDING=2): two granted requests with no rvalid -> cnt=2, obi_req_o=0, trans_ready_o=0 despite valid; one rvalid -> next cycle trans_ready_o=1.
- Simultaneous grant and rvalid with cnt=1 -> cnt remains 1; err=1 on rvalid -> resp_err_o=1.
- Stray rvalid with cnt=0 -> with CV32E40X_OBI_RESP_CHECK_EN: resp_valid_o=0, resp_unexp_o=1; without: resp_valid_o=1, resp_unexp_o=0; cnt=0 in both.
- Reset asserted while REGISTERED with cnt=1 -> obi_req_o=0 immediately, cnt=0, trans_ready_o=1 after release.
